// File: rtl/instruction_fetch_unit.sv
// Dual-issue fetch stage: owns the PC, drives both instruction-memory read ports, registers the pair for decode.
// Latency: 1 cycle from pc to out_valid; a redirect flushes the registered pair on the same edge.
// Backpressure: out_valid && !out_ready freezes pc, addresses and pair; define IFU_PERF_COUNTERS_EN for perf counters.
module instruction_fetch_unit #(
    parameter int                       ADDR_WIDTH_IM = 8,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH_IM-1:0] RESET_PC      = '0,
    parameter logic [INSTR_WIDTH-1:0]   HALT_INSTR    = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH_IM-1:0] redirect_pc,
    output logic [ADDR_WIDTH_IM-1:0] im_address_1,
    output logic [ADDR_WIDTH_IM-1:0] im_address_2,
    input  logic [INSTR_WIDTH-1:0]   im_read_data_1,
    input  logic [INSTR_WIDTH-1:0]   im_read_data_2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr_1,
    output logic [INSTR_WIDTH-1:0]   out_instr_2,
    output logic                     out_valid_2,
    output logic [ADDR_WIDTH_IM-1:0] out_pc,
    output logic                     halted
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0]              perf_fetch_cycles,
    output logic [31:0]              perf_instr_count,
    output logic [31:0]              perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0]   instr_1;
        logic [INSTR_WIDTH-1:0]   instr_2;
        logic [ADDR_WIDTH_IM-1:0] pc;
        logic                     vld_2;
    } pair_t;

    state_t                   state;
    logic [ADDR_WIDTH_IM-1:0] pc;
    pair_t                    pair;
    logic                     pair_vld;
    logic                     halt_q;

    logic load;
    logic slot1_halt;
    logic slot2_halt;

    assign im_address_1 = pc;
    assign im_address_2 = pc + ADDR_WIDTH_IM'(1);

    assign load       = (state == FETCH) && (!pair_vld || out_ready);
    assign slot1_halt = (im_read_data_1 == HALT_INSTR);
    assign slot2_halt = (im_read_data_2 == HALT_INSTR);

    assign out_valid   = pair_vld;
    assign out_instr_1 = pair.instr_1;
    assign out_instr_2 = pair.instr_2;
    assign out_pc      = pair.pc;
    assign out_valid_2 = pair.vld_2;
    assign halted      = halt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            pair     <= '0;
            pair_vld <= 1'b0;
            halt_q   <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over a same-cycle accept: the old pair never counts as transferred.
            state      <= FETCH;
            pc         <= redirect_pc;
            pair_vld   <= 1'b0;
            pair.vld_2 <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (load) begin
                        pair.instr_1 <= im_read_data_1;
                        pair.instr_2 <= im_read_data_2;
                        pair.pc      <= pc;
                        pair.vld_2   <= !slot1_halt;
                        pair_vld     <= 1'b1;
                        if (slot1_halt) begin
                            halt_q <= 1'b1;
                            state  <= HALTED;
                        end else if (slot2_halt) begin
                            pc     <= pc + ADDR_WIDTH_IM'(1);
                            halt_q <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            pc <= pc + ADDR_WIDTH_IM'(2);
                        end
                    end
                end
                HALTED: begin
                    if (pair_vld && out_ready) begin
                        pair_vld <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    logic       xfer;
    logic [1:0] xfer_cnt;

    assign xfer     = pair_vld && out_ready && !redirect_valid;
    assign xfer_cnt = xfer ? (pair.vld_2 ? 2'd2 : 2'd1) : 2'd0;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, inc};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cycles <= '0;
            perf_instr_count  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_fetch_cycles <= sat_add(perf_fetch_cycles, {1'b0, state == FETCH});
            perf_instr_count  <= sat_add(perf_instr_count, xfer_cnt);
            perf_stall_cycles <= sat_add(perf_stall_cycles, {1'b0, pair_vld && !out_ready});
        end
    end
`endif

endmodule
